mem_master: RTL

Bus-master controller that drives the single-port 4096×16 program/data memory from the CPU side. Two clients are arbitrated onto the one memory port: instruction fetch (read-only) and load/store (read or write, including stack PUSH/POP traffic). Arbitration is round-robin and only one access is outstanding at a time. The block owns the memory's `address`, `write_enable` and `data_in` pins, and captures `data_out` with the memory's posedge-write / negedge-read timing.

---
 rtl/mem_master_pkg.sv | 28 ++
 rtl/mem_master_arb.sv | 43 ++++
 rtl/mem_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the mem_master bus-master controller.
// Holds the address/data width defaults, FSM state and access-owner encodings,
// grant bit positions, and the saturating increment used by the perf counters.
package mem_master_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int PERF_W     = 16;

  // Bit positions inside the arbiter's one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/mem_master_arb.sv
// 2-way round-robin arbiter between instruction fetch and load/store.
// Latency: combinational grant; the 'last' owner register updates on a grant edge.
// Backpressure: grants only while en is high; a tie goes to the client not granted last.
// Ports: clk/rst (async active-high), en (controller idle), if_vld/ls_vld (requests),
//        gnt (one-hot, bit GNT_IF / GNT_LS).
module mem_master_arb
  import mem_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       if_vld,
  input  logic       ls_vld,
  output logic [1:0] gnt
);

  owner_t last_q, last_d;

  always_comb begin
    gnt         = 2'b00;
    gnt[GNT_LS] = en & ls_vld & (~if_vld | (last_q == OWN_IF));
    gnt[GNT_IF] = en & if_vld & (~ls_vld | (last_q == OWN_LS));
  end

  always_comb begin
    last_d = last_q;
    if (gnt[GNT_LS]) begin
      last_d = OWN_LS;
    end else if (gnt[GNT_IF]) begin
      last_d = OWN_IF;
    end
  end

  // Resetting to IF means the first tie after reset goes to load/store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_master.sv
// Bus-master controller driving the single-port program/data memory for fetch and load/store.
// Latency: accept at edge E, memory access cycle E..E+1, rsp_valid pulse E+1..E+2 (1 access / 2 cycles).
// Backpressure: readies are combinational in IDLE and low while an access is outstanding.
// Ports: if_* fetch request/response, ls_* load/store request/response, mem_* memory pins,
//        busy (access in progress). Optional macro MEM_MASTER_PERF_EN adds perf_rd_cnt/perf_wr_cnt.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_MASTER_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_rd_cnt,
  output logic [PERF_W-1:0] perf_wr_cnt
`endif
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_rsp_q, if_rsp_d;
  logic              ls_rsp_q, ls_rsp_d;
  logic [1:0]        gnt;
  logic              idle;

  assign idle = (state_q == IDLE);

  mem_master_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (idle),
    .if_vld (if_req_valid),
    .ls_vld (ls_req_valid),
    .gnt    (gnt)
  );

  assign if_req_ready = gnt[GNT_IF];
  assign ls_req_ready = gnt[GNT_LS];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every access is exactly one ACC cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|gnt) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. A grant and the previous access's response can never
  // coincide in the same cycle because grants only happen in IDLE.
  always_comb begin
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rsp_d    = 1'b0;
    ls_rsp_d    = 1'b0;

    if (gnt[GNT_LS]) begin
      owner_d     = OWN_LS;
      mem_addr_d  = ls_addr;
      mem_we_d    = ls_we;
      mem_wdata_d = ls_wdata;
    end else if (gnt[GNT_IF]) begin
      owner_d    = OWN_IF;
      mem_addr_d = if_addr;
      mem_we_d   = 1'b0;
    end

    if (state_q == ACC) begin
      // The memory drove mem_rdata at the negedge inside ACC; a store commits
      // at this same edge, so write_enable drops right after it.
      mem_we_d = 1'b0;
      if (owner_q == OWN_IF) begin
        if_rdata_d = mem_rdata;
        if_rsp_d   = 1'b1;
      end else begin
        ls_rsp_d = 1'b1;
        if (!mem_we_q) begin
          ls_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_IF;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_rsp_q    <= 1'b0;
      ls_rsp_q    <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_rsp_q    <= if_rsp_d;
      ls_rsp_q    <= ls_rsp_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;
  assign if_rsp_valid = if_rsp_q;
  assign ls_rsp_valid = ls_rsp_q;
  assign busy         = (state_q == ACC);

`ifdef MEM_MASTER_PERF_EN
  logic [PERF_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [PERF_W-1:0] wr_cnt_q, wr_cnt_d;

  // Counted at the edge that ends ACC, i.e. when the access actually completes.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == ACC) begin
      if (mem_we_q) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_d = sat_inc(rd_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign perf_rd_cnt = rd_cnt_q;
  assign perf_wr_cnt = wr_cnt_q;
`endif

endmodule
